// File: rtl/recv_if_gate_pkg.sv
// recv_if_gate_pkg
//   Shared types and widths for the IF range-gate capture block.
//   - bank_state_t : life cycle of one ping-pong capture bank
//   - CNT_W        : range counter width
//   - DROP_W       : dropped-PRI counter width
//   - sat_inc      : increment that holds at a limit instead of wrapping
package recv_if_gate_pkg;

  localparam int CNT_W  = 14;
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/recv_if_gate_dpram.sv
// gate_dpram
//   Simple dual-port RAM holding both capture banks; the address MSB selects
//   the bank. One write port, one read port with a registered output.
//   Ports:
//     clk, rst       clock / async active-high reset (clears only rdata)
//     we, waddr, wdata  write port
//     re, raddr      read enable / address; rdata updates one edge after re
//     rdata          registered read data, held while re is low
module gate_dpram #(
  parameter int WIDTH    = 12,
  parameter int GATE_LEN = 1024,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  // 2*GATE_LEN entries for the power-of-two gate lengths this block supports.
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register only updates on re, so a stalled consumer sees a stable
  // word without a separate holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/recv_if_gate.sv
// recv_if_gate
//   Captures a window of range cells from every PRI of an IF sample stream
//   into one of two ping-pong banks and streams complete gates out over a
//   valid/ready interface. PRIs that find no free bank are dropped and counted.
//   Ports:
//     clk, rst    clock / async active-high reset
//     pri_start   transmit-start pulse; the sample of that cycle is range cell 0
//     in          IF sample, one per clk
//     rd_data, rd_valid, rd_ready, rd_last   output stream, rd_last on last sample of a gate
//     overflow    one-cycle pulse when a PRI is dropped
//     drop_cnt    saturating count of dropped PRIs
module recv_if_gate
  import recv_if_gate_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int PRI        = 10000,
  parameter int GATE_START = 1024,
  parameter int GATE_LEN   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pri_start,
  input  logic [WIDTH-1:0]  in,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW    = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
  localparam int IDX_W = AW + 1;

  localparam logic [CNT_W-1:0] PRI_C   = CNT_W'(PRI);
  localparam logic [CNT_W-1:0] GFIRST  = CNT_W'(GATE_START);
  localparam logic [CNT_W-1:0] GLAST   = CNT_W'(GATE_START + GATE_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(GATE_LEN);
  localparam logic [IDX_W-1:0] IDX_LST = IDX_W'(GATE_LEN - 1);

  // ---------------------------------------------------------------- range
  logic [CNT_W-1:0] cnt_reg, cnt_next, rng;
  logic             started_reg, started_eff;
  logic             gate_open, gate_first, gate_last;

  // The range of the current cycle is 0 on pri_start itself, so the counter
  // register holds the range of the *next* sample.
  always_comb begin
    rng         = pri_start ? '0 : cnt_reg;
    started_eff = started_reg | pri_start;
    cnt_next    = sat_inc(rng, PRI_C);
    gate_open   = started_eff && (rng >= GFIRST) && (rng <= GLAST);
    gate_first  = gate_open && (rng == GFIRST);
    gate_last   = gate_open && (rng == GLAST);
  end

  // ---------------------------------------------------------------- banks
  bank_state_t bank_state_reg [2];
  bank_state_t bank_next      [2];
  logic [1:0]  full_vec, freed_vec, empty_vec;

  logic       fill_active_reg, fill_active_next;
  logic       fill_bank_reg, fill_bank_next;
  logic       done_pend_reg, done_pend_next;
  logic       done_bank_reg, done_bank_next;
  logic       oldest_reg, oldest_next;
  logic       abort, open_ok, drop, sel_bank, we, wbank;
  logic [AW-1:0] woff;

  // reader
  logic             rd_busy_reg, rd_busy_next;
  logic             rd_bank_reg, rd_bank_next;
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  logic             rd_valid_reg, rd_valid_next;
  logic             rd_last_reg, rd_last_next;
  logic             xfer_last, advance, more, reader_free;
  logic             claim_now, claim_bank, re;
  logic [AW:0]      raddr;

  logic              overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

  assign abort     = pri_start && fill_active_reg;
  assign xfer_last = rd_valid_reg && rd_ready && rd_last_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      assign full_vec[gi]  = (bank_state_reg[gi] == BANK_FULL);
      // A bank released this edge (aborted fill or final transfer) is
      // already free for a gate opening on the same edge.
      assign freed_vec[gi] = (abort && (fill_bank_reg == 1'(gi))) ||
                             (xfer_last && (rd_bank_reg == 1'(gi)));
      assign empty_vec[gi] = (bank_state_reg[gi] == BANK_EMPTY) || freed_vec[gi];
    end
  endgenerate

  // ---------------------------------------------------------------- writer
  always_comb begin
    sel_bank         = ~empty_vec[0];
    open_ok          = gate_first && (empty_vec != 2'b00);
    drop             = gate_first && (empty_vec == 2'b00);
    wbank            = open_ok ? sel_bank : fill_bank_reg;
    we               = gate_open && (open_ok || (fill_active_reg && !abort));
    woff             = AW'(rng - GFIRST);

    fill_active_next = fill_active_reg && !abort;
    fill_bank_next   = fill_bank_reg;
    done_pend_next   = 1'b0;
    done_bank_next   = done_bank_reg;
    if (open_ok) begin
      fill_active_next = 1'b1;
      fill_bank_next   = sel_bank;
    end
    // Completion is flagged now and promoted to FULL on the following edge.
    if (we && gate_last) begin
      fill_active_next = 1'b0;
      done_pend_next   = 1'b1;
      done_bank_next   = wbank;
    end
  end

  // ---------------------------------------------------------------- reader
  always_comb begin
    advance       = !rd_valid_reg || rd_ready;
    more          = rd_busy_reg && (rd_idx_reg != IDX_END);
    reader_free   = !rd_busy_reg || xfer_last;
    // With both banks full the one that completed first is read first.
    claim_bank    = (full_vec == 2'b11) ? oldest_reg : full_vec[1];
    claim_now     = 1'b0;

    rd_busy_next  = rd_busy_reg && !xfer_last;
    rd_bank_next  = rd_bank_reg;
    rd_idx_next   = rd_idx_reg;
    rd_valid_next = rd_valid_reg;
    rd_last_next  = rd_last_reg;
    re            = 1'b0;
    raddr         = {rd_bank_reg, rd_idx_reg[AW-1:0]};

    if (advance) begin
      if (more) begin
        re            = 1'b1;
        rd_idx_next   = rd_idx_reg + 1'b1;
        rd_valid_next = 1'b1;
        rd_last_next  = (rd_idx_reg == IDX_LST);
      end else if (reader_free && (full_vec != 2'b00)) begin
        claim_now     = 1'b1;
        re            = 1'b1;
        raddr         = {claim_bank, {AW{1'b0}}};
        rd_busy_next  = 1'b1;
        rd_bank_next  = claim_bank;
        rd_idx_next   = IDX_W'(1);
        rd_valid_next = 1'b1;
        rd_last_next  = (IDX_LST == '0);
      end else begin
        rd_valid_next = 1'b0;
        rd_last_next  = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- bank states
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_next[i] = bank_state_reg[i];
      if (freed_vec[i]) begin
        bank_next[i] = BANK_EMPTY;
      end
      if (done_pend_reg && (done_bank_reg == 1'(i))) begin
        bank_next[i] = BANK_FULL;
      end
      if (claim_now && (claim_bank == 1'(i))) begin
        bank_next[i] = BANK_READING;
      end
      if (open_ok && (sel_bank == 1'(i))) begin
        bank_next[i] = BANK_FILLING;
      end
    end
    oldest_next = oldest_reg;
    if (done_pend_reg) begin
      oldest_next = (bank_next[~done_bank_reg] == BANK_FULL) ? oldest_reg : done_bank_reg;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg         <= '0;
      started_reg     <= 1'b0;
      bank_state_reg[0] <= BANK_EMPTY;
      bank_state_reg[1] <= BANK_EMPTY;
      fill_active_reg <= 1'b0;
      fill_bank_reg   <= 1'b0;
      done_pend_reg   <= 1'b0;
      done_bank_reg   <= 1'b0;
      oldest_reg      <= 1'b0;
      rd_busy_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      rd_idx_reg      <= '0;
      rd_valid_reg    <= 1'b0;
      rd_last_reg     <= 1'b0;
      overflow_reg    <= 1'b0;
      drop_cnt_reg    <= '0;
    end else begin
      cnt_reg         <= cnt_next;
      started_reg     <= started_eff;
      bank_state_reg[0] <= bank_next[0];
      bank_state_reg[1] <= bank_next[1];
      fill_active_reg <= fill_active_next;
      fill_bank_reg   <= fill_bank_next;
      done_pend_reg   <= done_pend_next;
      done_bank_reg   <= done_bank_next;
      oldest_reg      <= oldest_next;
      rd_busy_reg     <= rd_busy_next;
      rd_bank_reg     <= rd_bank_next;
      rd_idx_reg      <= rd_idx_next;
      rd_valid_reg    <= rd_valid_next;
      rd_last_reg     <= rd_last_next;
      overflow_reg    <= drop;
      if (drop && (drop_cnt_reg != {DROP_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  gate_dpram #(
    .WIDTH   (WIDTH),
    .GATE_LEN(GATE_LEN),
    .ADDR_W  (AW + 1)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr({wbank, woff}),
    .wdata(in),
    .re   (re),
    .raddr(raddr),
    .rdata(rd_data)
  );

  assign rd_valid = rd_valid_reg;
  assign rd_last  = rd_last_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_recv_if_gate.sv
// tb_recv_if_gate
//   Directed scenarios with randomized data offsets and consumer back-pressure.
//   A gate-level reference model (range index, bank occupancy count, queue of
//   expected output words) predicts every transfer, overflow pulse and the
//   drop counter.
module tb_recv_if_gate;

  localparam int W   = 12;
  localparam int PRI = 10000;
  localparam int GS  = 1024;
  localparam int LEN = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         pri_start;
  logic [W-1:0] in;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         rd_ready;
  logic         rd_last;
  logic         overflow;
  logic [15:0]  drop_cnt;

  recv_if_gate #(
    .WIDTH     (W),
    .PRI       (PRI),
    .GATE_START(GS),
    .GATE_LEN  (LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pri_start(pri_start),
    .in       (in),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  int           r          = 0;
  bit           started    = 0;
  bit           filling    = 0;
  int           banks_used = 0;
  int           offset     = 0;
  int           exp_drop   = 0;
  bit           exp_ovf    = 0;
  int           xfer_cnt   = 0;
  logic [W-1:0] fill_q [$];
  logic [W:0]   exp_q  [$];
  bit           prev_stall = 0;
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    r = 0; started = 0; filling = 0; banks_used = 0;
    exp_drop = 0; exp_ovf = 0; prev_stall = 0;
    fill_q.delete(); exp_q.delete();
  endtask

  // One clock cycle, entered and left at a falling edge: observe outputs,
  // account for the transfer that the coming rising edge performs, advance the
  // model, then drive inputs.
  task automatic tick(input bit ps, input bit rdy);
    logic [W:0]   e;
    logic [W-1:0] din;
    chk("overflow", overflow, exp_ovf);
    exp_ovf = 0;
    if (prev_stall) begin
      chk("stall_valid", rd_valid, 1);
      chk("stall_data", rd_data, prev_data);
      chk("stall_last", rd_last, prev_last);
    end
    if (rd_valid && rdy) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_xfer: got data %0h last %0b expected no output", rd_data, rd_last);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        xfer_cnt++;
        chk("rd_data", rd_data, e[W-1:0]);
        chk("rd_last", rd_last, e[W]);
        if (e[W]) banks_used--;
      end
    end
    prev_stall = rd_valid && !rdy;
    prev_data  = rd_data;
    prev_last  = rd_last;

    if (ps) begin
      if (filling) begin
        filling = 0; banks_used--; fill_q.delete();
      end
      r = 0; started = 1;
    end else if (r < PRI) begin
      r++;
    end
    din = W'(r + offset);
    if (started && r >= GS && r < GS + LEN) begin
      if (r == GS) begin
        if (banks_used < 2) begin
          banks_used++; filling = 1;
        end else begin
          exp_drop++; exp_ovf = 1;
        end
      end
      if (filling) begin
        fill_q.push_back(din);
        if (r == GS + LEN - 1) begin
          for (int i = 0; i < LEN; i++) exp_q.push_back({(i == LEN - 1), fill_q[i]});
          fill_q.delete();
          filling = 0;
        end
      end
    end

    pri_start = ps;
    rd_ready  = rdy;
    in        = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  // mode 0: ready low, 1: ready high, 2: ready random 50 %
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1));
    end
  endtask

  initial begin
    int k;
    int x0;
    rst = 1'b1; pri_start = 1'b0; in = '0; rd_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;

    // Before any pri_start nothing may be captured.
    run(3000, 1);

    // S1: in = range index, single gate, full-rate drain.
    offset = 0; x0 = xfer_cnt;
    tick(1'b1, 1'b1);
    run(GS + LEN - 1, 1);
    k = 0;
    while (rd_valid !== 1'b1 && k < 10) begin
      tick(1'b0, 1'b1); k++;
    end
    tests_run++;
    assert (k <= 4) else begin
      tests_failed++;
      $error("FAIL s1_latency: got %0d cycles expected at most 4", k);
    end
    run(1100, 1);
    $display("[TB] S1 gate transfers=%0d", xfer_cnt - x0);
    chk("s1_count", xfer_cnt - x0, LEN);
    chk("s1_left", exp_q.size(), 0);

    // S2: ready low for three PRIs, third PRI dropped.
    x0 = xfer_cnt;
    for (int p = 0; p < 3; p++) begin
      offset = int'($urandom_range(0, 4095));
      tick(1'b1, 1'b0);
      run(2199, 0);
    end
    chk("s2_drop", drop_cnt, 1);
    chk("s2_drop_model", drop_cnt, exp_drop);
    run(2200, 1);
    $display("[TB] S2 transfers=%0d drop_cnt=%0d", xfer_cnt - x0, drop_cnt);
    chk("s2_count", xfer_cnt - x0, 2 * LEN);
    chk("s2_left", exp_q.size(), 0);

    // S3: pri_start at range 1500 aborts the fill; next gate intact.
    x0 = xfer_cnt;
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'b1);
    run(1499, 1);
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'b1);
    run(3200, 1);
    $display("[TB] S3 transfers=%0d", xfer_cnt - x0);
    chk("s3_count", xfer_cnt - x0, LEN);
    chk("s3_left", exp_q.size(), 0);

    // S4: random back-pressure over two PRIs.
    x0 = xfer_cnt;
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'($urandom_range(0, 1)));
    run(2999, 2);
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'($urandom_range(0, 1)));
    run(2999, 2);
    run(4000, 2);
    $display("[TB] S4 transfers=%0d", xfer_cnt - x0);
    chk("s4_count", xfer_cnt - x0, 2 * LEN);
    chk("s4_left", exp_q.size(), 0);

    // S5: asynchronous reset in the middle of a read.
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'b1);
    run(2100, 1);
    chk("s5_pre_valid", rd_valid, 1);
    pri_start = 1'b0; rd_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", rd_valid, 0);
    chk("s5_rst_last", rd_last, 0);
    chk("s5_rst_data", rd_data, 0);
    chk("s5_rst_drop", drop_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    run(1500, 1);
    x0 = xfer_cnt;
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'b1);
    run(3200, 1);
    $display("[TB] S5 transfers after reset=%0d", xfer_cnt - x0);
    chk("s5_count", xfer_cnt - x0, LEN);
    chk("s5_left", exp_q.size(), 0);

    // S6: one PRI then 20000 cycles without pri_start; range saturates.
    x0 = xfer_cnt;
    offset = int'($urandom_range(0, 4095));
    tick(1'b1, 1'b1);
    run(20000, 1);
    $display("[TB] S6 transfers=%0d", xfer_cnt - x0);
    chk("s6_count", xfer_cnt - x0, LEN);
    chk("s6_left", exp_q.size(), 0);
    chk("s6_drop", drop_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/recv_if_gate.md
RECV_IF_GATE -- requirements
Module: recv_if_gate

Interface
REQ-001 Parameter WIDTH, default 12, sample width in bits.
REQ-002 Parameter PRI, default 10000, nominal PRI length in clk cycles; the range counter saturates at PRI.
REQ-003 Parameter GATE_START, default 1024, first range cell captured, counted from pri_start.
REQ-004 Parameter GATE_LEN, default 1024, number of samples captured per PRI; power of two, at most 1024.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 pri_start  in  1  one-cycle pulse marking transmit start; the sample of the same cycle is range cell 0.
REQ-008 in  in  WIDTH  IF sample, two's complement, one sample per clk.
REQ-009 rd_data  out  WIDTH  captured sample.
REQ-010 rd_valid  out  1  rd_data is valid.
REQ-011 rd_ready  in  1  consumer accepts rd_data.
REQ-012 rd_last  out  1  marks the last sample of a gate; qualified by rd_valid.
REQ-013 overflow  out  1  one-cycle pulse when a PRI is dropped.
REQ-014 drop_cnt  out  16  count of dropped PRIs; saturates at 16'hFFFF.

Function
REQ-015 The range counter shall be 14 bits, load 0 on pri_start, increment otherwise, and hold at PRI without wrapping.
REQ-016 Before the first pri_start after reset, the block shall capture nothing.
REQ-017 The gate shall be open while GATE_START <= range counter < GATE_START+GATE_LEN.
REQ-018 While the gate is open, the block shall write `in` to the write bank at address (counter - GATE_START).
REQ-019 The block shall contain two banks (ping-pong), each with state EMPTY, FILLING, FULL or READING.
REQ-020 When the gate opens and an EMPTY bank exists, that bank shall go to FILLING; if both banks are EMPTY, bank 0 is chosen.
REQ-021 When the gate opens and no bank is EMPTY, the PRI shall be dropped: no write, overflow pulses for one cycle, and drop_cnt increments.
REQ-022 After the last gate sample is written, the bank shall go FILLING -> FULL on the next edge.
REQ-023 A pri_start while a bank is FILLING shall abort the fill, return the bank to EMPTY, and start a new PRI; a partial gate is never output.
REQ-024 The reader shall take FULL banks in fill order and set the bank to READING.
REQ-025 RAM read latency shall be 1 cycle.
REQ-026 rd_valid shall assert within 3 cycles after a bank becomes FULL.
REQ-027 Output shall follow valid/ready: a transfer occurs on a cycle with rd_valid && rd_ready.
REQ-028 rd_data and rd_last shall hold stable while rd_valid && !rd_ready.
REQ-029 Streaming with rd_ready held high shall sustain 1 sample per cycle.
REQ-030 rd_last shall accompany sample index GATE_LEN-1.
REQ-031 After the rd_last transfer, the bank shall return to EMPTY on the same edge.
REQ-032 A bank freed on the same edge that a gate opens shall count as EMPTY for that gate open.
REQ-033 Samples shall be output unmodified, in range order.

Reset
REQ-034 rst shall put both banks EMPTY and clear the range counter.
REQ-035 rst shall clear the started flag, drop_cnt, rd_valid, rd_last, rd_data and overflow to 0.
REQ-036 rst shall take effect asynchronously and cancel any in-progress fill or read; RAM contents need not be cleared.

Structure
REQ-037 A shared package shall hold the bank-state enumeration, the counter width (14) and the drop-counter width (16).
REQ-038 Sub-module gate_dpram shall be a simple dual-port RAM of 2*GATE_LEN x WIDTH with a registered read; bank select is the address MSB.

Verification
REQ-039 Scenario 1: in = range index, pri_start at t0 -> exactly 1024 samples with values 1024..2047; rd_last on 2047; no overflow.
REQ-040 Scenario 2: rd_ready=0 for three PRIs -> two banks FULL, third PRI dropped; overflow pulses once; drop_cnt=1.
REQ-041 Scenario 3: pri_start at count 1500, mid-gate -> no output from that PRI; the next full gate is output intact.
REQ-042 Scenario 4: rd_ready toggled randomly at 50% -> data sequence intact and stable while stalled; rd_last only on index 1023.
REQ-043 Scenario 5: rst asserted mid-read -> rd_valid=0 immediately; after release, no output until a new pri_start and a complete gate.
REQ-044 Scenario 6: no pri_start for 20000 cycles -> counter holds at 10000 and no capture occurs.
